// File: rtl/vid_pkg.sv
// Shared video-path constants and the frame reader state type.
package vid_pkg;

  localparam int H_RES_DEF  = 320;
  localparam int V_RES_DEF  = 240;
  localparam int PIX_W_DEF  = 12;
  localparam int ADDR_W_DEF = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO whose head word is presented directly as the stream beat.
module stream_skid_buf #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  // NOTE: storage words are not reset; head_o is gated by valid_o, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/frame_stream_reader.sv
// Streams whole frames out of a 1-cycle-latency frame buffer as Avalon-ST
// beats, tagging SOP/EOP and latching the filter mode per frame.
module frame_stream_reader
  import vid_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        mode_in,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  st_data,
  output logic              st_valid,
  output logic              st_sop,
  output logic              st_eop,
  input  logic              st_ready,
  output logic [2:0]        mode_out,
  output logic              frame_done,
  output logic [7:0]        frame_cnt
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int BUF_W = PIX_W + 2;

  state_e            state_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;
  logic              data_vld_q;
  logic              sop_tag_q;
  logic              eop_tag_q;
  logic [2:0]        mode_q;
  logic              done_q;
  logic [7:0]        cnt_q;

  logic [1:0]        fifo_cnt;
  logic [BUF_W-1:0]  head;
  logic [1:0]        credit;
  logic              pop;
  logic              issue;
  logic              first_pix;
  logic              last_col;
  logic              last_pix;
  logic              eop_accept;

  // Credit covers FIFO words left after this pop plus the read whose data returns now.
  assign pop        = st_valid & st_ready;
  assign credit     = fifo_cnt - {1'b0, pop} + {1'b0, data_vld_q};
  assign issue      = (state_q == ST_RUN) && (credit < 2'd2);
  assign first_pix  = (col_q == '0) && (row_q == '0);
  assign last_col   = (col_q == COL_W'(H_RES - 1));
  assign last_pix   = last_col && (row_q == ROW_W'(V_RES - 1));
  assign eop_accept = pop & st_eop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      data_vld_q <= 1'b0;
      sop_tag_q  <= 1'b0;
      eop_tag_q  <= 1'b0;
      mode_q     <= 3'd0;
      done_q     <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      done_q     <= 1'b0;
      data_vld_q <= issue;
      sop_tag_q  <= issue & first_pix;
      eop_tag_q  <= issue & last_pix;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q <= ST_RUN;
            mode_q  <= mode_in;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (last_pix) begin
              col_q   <= '0;
              row_q   <= '0;
              addr_q  <= '0;
              state_q <= ST_DRAIN;
            end else begin
              addr_q <= addr_q + 1'b1;
              if (last_col) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          // Enable is only consulted here, so a frame in progress always completes.
          if (eop_accept) begin
            done_q <= 1'b1;
            cnt_q  <= cnt_q + 8'd1;
            if (enable) begin
              state_q <= ST_RUN;
              mode_q  <= mode_in;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  stream_skid_buf #(.W(BUF_W)) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (data_vld_q),
    .push_data_i ({eop_tag_q, sop_tag_q, rd_data}),
    .pop_i       (pop),
    .valid_o     (st_valid),
    .head_o      (head),
    .count_o     (fifo_cnt)
  );

  assign {st_eop, st_sop, st_data} = head;
  assign rd_addr    = addr_q;
  assign mode_out   = mode_q;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_frame_stream_reader.sv
// Scoreboard bench: whole expected frames are queued by the stimulus and
// consumed by an independent monitor on every accepted beat.
module tb_frame_stream_reader;

  localparam int H_RES  = 8;
  localparam int V_RES  = 4;
  localparam int PIX_W  = 12;
  localparam int ADDR_W = 17;
  localparam int NPIX   = H_RES * V_RES;
  localparam int BUDGET = 4000;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sop;
    logic             eop;
    logic [2:0]       mode;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [2:0]        mode_in;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [PIX_W-1:0]  st_data;
  logic              st_valid, st_sop, st_eop, st_ready;
  logic [2:0]        mode_out;
  logic              frame_done;
  logic [7:0]        frame_cnt;

  logic [PIX_W-1:0]  fb [NPIX];
  beat_t             exp_q [$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, beats_seen = 0, exp_frames = 0, last_done_cyc = -1;
  bit mon_en = 0, free_run = 0, rnd_ready = 0, ready_fix = 0;

  frame_stream_reader #(.H_RES(H_RES), .V_RES(V_RES), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode_in(mode_in),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready), .mode_out(mode_out), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer: registered read, data valid the cycle after the address.
  always @(posedge clk) rd_data <= fb[int'(rd_addr) % NPIX];

  initial begin
    st_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      st_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : ready_fix;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_frame(input logic [2:0] m);
    beat_t b;
    for (int a = 0; a < NPIX; a++) begin
      b.data = fb[a];
      b.sop  = (a == 0);
      b.eop  = (a == NPIX - 1);
      b.mode = m;
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int target);
    int guard = 0;
    while (beats_seen < target && guard < BUDGET) begin tick(); guard++; end
    if (guard >= BUDGET) check("wait_beats", 32'(beats_seen), 32'(target));
  endtask

  task automatic wait_frames(input int target);
    int guard = 0;
    while (exp_frames < target && guard < BUDGET) begin tick(); guard++; end
    if (guard >= BUDGET) check("wait_frames", 32'(exp_frames), 32'(target));
  endtask

  task automatic measure_latency();
    int lat = 0;
    do begin tick(); lat++; end while (!st_valid && lat < 20);
    check("first_beat_latency", 32'(lat), 32'd3);
  endtask

  // Two frames; mode changes mid-frame 1, enable drops mid-frame 2.
  task automatic run_phase(input logic [2:0] m1, input logic [2:0] m2, input bit rnd);
    int base_beats, base_frames;
    base_beats  = beats_seen;
    base_frames = exp_frames;
    free_run = !rnd; rnd_ready = rnd; ready_fix = 1'b1; last_done_cyc = -1;
    mode_in = m1;
    push_frame(m1);
    push_frame(m2);
    repeat (2) tick();
    enable = 1'b1;
    measure_latency();
    wait_beats(base_beats + 10);
    mode_in = m2;
    wait_beats(base_beats + NPIX + 5);
    enable = 1'b0;
    wait_frames(base_frames + 2);
    repeat (10) tick();
    check("idle_valid", 32'(st_valid), 32'd0);
    check("idle_addr", 32'(rd_addr), 32'd0);
    check("frame_cnt_final", 32'(frame_cnt), 32'(exp_frames % 256));
    check("mode_out_held", 32'(mode_out), 32'(m2));
  endtask

  task automatic reset_phase();
    int base_beats;
    base_beats = beats_seen;
    free_run = 1'b0; rnd_ready = 1'b1; last_done_cyc = -1;
    mode_in = 3'd6;
    push_frame(3'd6);
    enable = 1'b1;
    wait_beats(base_beats + 20);
    rnd_ready = 1'b0; ready_fix = 1'b0;
    repeat (3) tick();
    reset = 1'b1; enable = 1'b0; mon_en = 0;
    tick();
    check("rst_mid_valid", 32'(st_valid), 32'd0);
    check("rst_mid_cnt", 32'(frame_cnt), 32'd0);
    check("rst_mid_addr", 32'(rd_addr), 32'd0);
    check("rst_mid_mode", 32'(mode_out), 32'd0);
    check("rst_mid_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    tick();
    mon_en = 1; free_run = 1'b1; ready_fix = 1'b1;
    base_beats = beats_seen;
    mode_in = 3'd1;
    push_frame(3'd1);
    repeat (2) tick();
    enable = 1'b1;
    measure_latency();
    wait_beats(base_beats + 5);
    enable = 1'b0;
    wait_frames(1);
    repeat (10) tick();
    check("post_rst_cnt", 32'(frame_cnt), 32'd1);
    check("post_rst_idle", 32'(st_valid), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted beat and watches framing.
  logic [PIX_W+1:0] held;
  bit stall_prev = 0, done_due = 0, in_frame = 0;
  int gap_cnt = 0;
  always @(negedge clk) begin
    beat_t b;
    if (!mon_en) begin
      stall_prev = 0; done_due = 0; in_frame = 0; gap_cnt = 0;
    end else begin
      if (done_due) begin
        check("frame_done", 32'(frame_done), 32'd1);
        check("frame_cnt_inc", 32'(frame_cnt), 32'(exp_frames % 256));
        done_due = 0;
        last_done_cyc = cyc;
      end else begin
        check("frame_done_quiet", 32'(frame_done), 32'd0);
      end
      if (stall_prev && st_valid) check("stall_hold", 32'({st_eop, st_sop, st_data}), 32'(held));
      if (in_frame && !st_valid && free_run) gap_cnt++;
      if (st_valid && st_ready) begin
        if (exp_q.size() == 0) begin
          check("exp_queue_size", 32'(exp_q.size()), 32'd1);
        end else begin
          b = exp_q.pop_front();
          check("st_data", 32'(st_data), 32'(b.data));
          check("st_sop", 32'(st_sop), 32'(b.sop));
          check("st_eop", 32'(st_eop), 32'(b.eop));
          check("mode_out", 32'(mode_out), 32'(b.mode));
          if (b.sop) begin
            in_frame = 1; gap_cnt = 0;
            if (free_run && last_done_cyc >= 0) check("sop_after_done", 32'(cyc - last_done_cyc), 32'd2);
          end
          if (b.eop) begin
            in_frame = 0;
            if (free_run) check("in_frame_gaps", 32'(gap_cnt), 32'd0);
            exp_frames++;
            done_due = 1;
          end
        end
        beats_seen++;
      end
      stall_prev = st_valid && !st_ready;
      held = {st_eop, st_sop, st_data};
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; mode_in = 3'd0;
    for (int a = 0; a < NPIX; a++) fb[a] = PIX_W'($urandom);
    repeat (3) tick();
    check("rst_valid", 32'(st_valid), 32'd0);
    check("rst_sop", 32'(st_sop), 32'd0);
    check("rst_eop", 32'(st_eop), 32'd0);
    check("rst_data", 32'(st_data), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    check("rst_mode", 32'(mode_out), 32'd0);
    reset = 1'b0;
    mon_en = 1;
    run_phase(3'd3, 3'd5, 1'b0);
    run_phase(3'd0, 3'd2, 1'b1);
    run_phase(3'd7, 3'd4, 1'b1);
    reset_phase();
    check("leftover_beats", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
